// File: rtl/multi_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
// Each channel emits a divided square wave and a once-per-period tick.
`timescale 1ns/1ps

module multi_clock_divider_ch #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             clock_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic [CNT_W-1:0] ld_val;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        ld_val = (value < TWO) ? TWO : value;
        wrap   = (cnt_q == div_q - ONE);
        cnt_d  = cnt_q;
        div_d  = div_q;
        pdiv_d = pdiv_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
        end else if (enable) begin
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            // Phase uses the divisor of the period that is ending.
            clk_d  = (cnt_d >= (div_q >> 1));
            tick_d = wrap;
            if (wrap && pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end
        end
        // A load on the apply edge stays pending for the next wrap.
        if (load) begin
            pdiv_d = ld_val;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            div_q  <= DEF;
            pdiv_q <= DEF;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clock_out = clk_q;
    assign tick      = tick_q;
    assign pend      = pend_q;

endmodule

module multi_clock_divider #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              restart,
    input  logic [NUM_CH-1:0] div_load,
    input  logic [CNT_W-1:0]  div_value,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        multi_clock_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .enable    (enable),
            .restart   (restart),
            .load      (div_load[g]),
            .value     (div_value),
            .clock_out (clock_out[g]),
            .tick      (tick[g]),
            .pend      (pend[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider with a cycle scoreboard.
// Reference state is advanced per edge and compared after the edge.
`timescale 1ns/1ps

module tb_multi_clock_divider;

    logic        clock_in;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [1:0]  div_load;
    logic [15:0] div_value;
    logic [1:0]  clock_out;
    logic [1:0]  tick;
    logic [1:0]  pend;

    multi_clock_divider #(
        .NUM_CH      (2),
        .CNT_W       (16),
        .DEFAULT_DIV (2)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .enable    (enable),
        .restart   (restart),
        .div_load  (div_load),
        .div_value (div_value),
        .clock_out (clock_out),
        .tick      (tick),
        .pend      (pend)
    );

    initial clock_in = 1'b0;
    always #10 clock_in = ~clock_in;

    typedef struct packed {
        logic [1:0] clk;
        logic [1:0] tck;
        logic [1:0] pnd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          m_cnt [2];
    int          m_div [2];
    int          m_pdiv[2];
    logic [1:0]  m_clk, m_tck, m_pnd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_div[i]  = 2;
            m_pdiv[i] = 2;
        end
        m_clk = '0;
        m_tck = '0;
        m_pnd = '0;
        sb.delete();
    endtask

    // Reference behaviour for one rising edge with the present inputs.
    task automatic model_edge();
        int cl;
        int apply;
        cl = (div_value < 2) ? 2 : int'(div_value);
        for (int i = 0; i < 2; i++) begin
            apply = 0;
            if (restart) begin
                m_cnt[i] = 0;
                m_clk[i] = 1'b0;
                m_tck[i] = 1'b0;
                apply    = m_pnd[i];
            end else if (enable) begin
                m_tck[i] = (m_cnt[i] == m_div[i] - 1);
                m_cnt[i] = m_tck[i] ? 0 : m_cnt[i] + 1;
                m_clk[i] = (m_cnt[i] >= m_div[i] / 2);
                apply    = m_tck[i] && m_pnd[i];
            end else begin
                m_tck[i] = 1'b0;
            end
            if (apply != 0) begin
                m_div[i] = m_pdiv[i];
                m_pnd[i] = 1'b0;
            end
            if (div_load[i]) begin
                m_pdiv[i] = cl;
                m_pnd[i]  = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_edge();
        sb.push_back('{clk: m_clk, tck: m_tck, pnd: m_pnd});
        @(posedge clock_in);
        #1;
        e = sb.pop_front();
        chk("sb_clock_out", 32'(clock_out), 32'(e.clk));
        chk("sb_tick", 32'(tick), 32'(e.tck));
        chk("sb_pend", 32'(pend), 32'(e.pnd));
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick[ch] && n < maxc);
        chk("tick_timeout", 32'(tick[ch]), 32'd1);
    endtask

    task automatic async_reset();
        #4;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_clock_out", 32'(clock_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        int   n;
        int   t0, t1, nr;
        logic prev, saved;
        int   pat[5];
        pat = '{0, 0, 1, 1, 1};
        reset_n   = 1'b0;
        enable    = 1'b1;
        restart   = 1'b0;
        div_load  = '0;
        div_value = '0;
        model_reset();

        #5;
        chk("por_clock_out", 32'(clock_out), 32'd0);
        chk("por_pend", 32'(pend), 32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;

        // Reset mid-run discards a pending load
        repeat (3) cycle();
        div_value = 16'd9;
        div_load  = 2'b01;
        cycle();
        div_load  = '0;
        chk("pre_rst_pend", 32'(pend), 32'd1);
        async_reset();

        // Default /2: rising edge every 40 ns
        prev = 1'b0;
        t0 = 0;
        t1 = 0;
        nr = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (clock_out[0] && !prev) begin
                if (nr == 0) t0 = int'($time);
                if (nr == 1) t1 = int'($time);
                nr++;
            end
            prev = clock_out[0];
        end
        chk("rise_count", 32'(nr), 32'd4);
        chk("rise_period_ns", 32'(t1 - t0), 32'd40);

        // Odd divisor 5 on ch0, ch1 remains /2
        div_value = 16'd5;
        div_load  = 2'b01;
        cycle();
        div_load  = '0;
        chk("t2_pend", 32'(pend), 32'd1);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        chk("t2_rs_clk", 32'(clock_out), 32'd0);
        chk("t2_rs_pend", 32'(pend), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            chk("t2_pattern", 32'(clock_out[0]), 32'(pat[k % 5]));
            chk("t2_tick0", 32'(tick[0]), 32'(k % 5 == 0));
            chk("t2_tick1", 32'(tick[1]), 32'(k % 2 == 0));
        end

        // Deferred load: 3 loaded at cnt=2 of an 8-period
        div_value = 16'd8;
        div_load  = 2'b01;
        cycle();
        div_load  = '0;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        repeat (2) cycle();
        div_value = 16'd3;
        div_load  = 2'b01;
        cycle();
        div_load  = '0;
        chk("t3_pend_set", 32'(pend[0]), 32'd1);
        wait_tick(0, 20, n);
        chk("t3_rest_of_8", 32'(n), 32'd5);
        chk("t3_pend_clr", 32'(pend[0]), 32'd0);
        wait_tick(0, 20, n);
        chk("t3_period3", 32'(n), 32'd3);

        // Clamp of 0 and 1, then overwrite 7 by 9
        div_value = 16'd0;
        div_load  = 2'b01;
        cycle();
        div_value = 16'd1;
        cycle();
        div_load  = '0;
        chk("t4_pend_hold", 32'(pend[0]), 32'd1);
        wait_tick(0, 20, n);
        chk("t4_wrap3", 32'(n), 32'd1);
        chk("t4_pend_clr", 32'(pend[0]), 32'd0);
        wait_tick(0, 20, n);
        chk("t4_clamp2", 32'(n), 32'd2);
        enable    = 1'b0;
        div_load  = 2'b01;
        div_value = 16'd7;
        cycle();
        div_value = 16'd9;
        cycle();
        div_load  = '0;
        enable    = 1'b1;
        chk("t4_pend_79", 32'(pend[0]), 32'd1);
        wait_tick(0, 20, n);
        chk("t4_wrap2", 32'(n), 32'd2);
        wait_tick(0, 20, n);
        chk("t4_period9", 32'(n), 32'd9);

        // Freeze for 6 cycles mid-period stretches it by 6
        repeat (3) cycle();
        saved  = clock_out[0];
        enable = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("t5_frozen", 32'(clock_out[0]), 32'(saved));
            chk("t5_tick0", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        wait_tick(0, 20, n);
        chk("t5_stretched", 32'(3 + 6 + n), 32'd15);

        // Restart applies pending on ch0, same-edge load stays on ch1
        div_value = 16'd4;
        div_load  = 2'b01;
        cycle();
        restart   = 1'b1;
        div_value = 16'd6;
        div_load  = 2'b10;
        cycle();
        restart   = 1'b0;
        div_load  = '0;
        chk("t6_clk", 32'(clock_out), 32'd0);
        chk("t6_tick", 32'(tick), 32'd0);
        chk("t6_pend", 32'(pend), 32'd2);
        cycle();
        chk("t6_pend1_hold", 32'(pend[1]), 32'd1);
        cycle();
        chk("t6_pend1_clr", 32'(pend[1]), 32'd0);
        chk("t6_tick1", 32'(tick[1]), 32'd1);
        wait_tick(1, 20, n);
        chk("t6_period6", 32'(n), 32'd6);
        wait_tick(0, 20, n);
        wait_tick(0, 20, n);
        chk("t6_period4", 32'(n), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
